// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-memory port.
//   mem_type_e : transfer size code (CPU func3)
//   CAUSE_*    : error cause codes reported by data_mem_responder
//   LOAD/STORE : opcodes shared with the CPU decode side
package mem_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'd0,
    MT_H  = 3'd1,
    MT_W  = 3'd2,
    MT_BU = 3'd4,
    MT_HU = 3'd5
  } mem_type_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_BOTH_EN  = 2'b11;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half/word lane steering for one 32-bit RAM word (purely combinational).
//   word_i    : current RAM word at the addressed index
//   off_i     : byte offset addr[1:0]
//   type_i    : transfer code
//   wr_data_i : right-justified store data
//   rd_data_o : right-justified, zero-extended load data (0 for undefined codes)
//   wr_word_o : word_i with the addressed lanes replaced by store data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  type_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic [31:0] wr_word_o
);

  always_comb begin
    rd_data_o = '0;
    wr_word_o = word_i;
    // signed/unsigned variants steer identically; the CPU sign-extends
    case (type_i)
      MT_B, MT_BU: begin
        rd_data_o[7:0]                  = word_i[{off_i, 3'b000} +: 8];
        wr_word_o[{off_i, 3'b000} +: 8] = wr_data_i[7:0];
      end
      MT_H, MT_HU: begin
        rd_data_o[15:0]                    = word_i[{off_i[1], 4'b0000} +: 16];
        wr_word_o[{off_i[1], 4'b0000} +: 16] = wr_data_i[15:0];
      end
      MT_W: begin
        rd_data_o = word_i;
        wr_word_o = wr_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the CPU stage-3 load/store port.
// Zero-latency combinational loads, synchronous stores, sticky first-error
// capture and saturating legal-access counters.
//   CLK, rst                     : clock, synchronous active-low reset
//   MEM_addr/MEM_WR_out/MEM_type : byte address, store data, transfer code
//   MEM_rd_en/MEM_wr_en          : load / store request this cycle
//   MEM_data                     : load data (0 unless a legal load)
//   err/err_addr/err_cause       : first illegal access since reset
//   ld_count/st_count            : legal loads / stores completed
module data_mem_responder
  import mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int CNT_W       = 16,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [31:0]      MEM_addr,
  input  logic [31:0]      MEM_WR_out,
  input  logic [2:0]       MEM_type,
  input  logic             MEM_rd_en,
  input  logic             MEM_wr_en,
  output logic [31:0]      MEM_data,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [1:0]       err_cause,
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count
);

  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [1:0]       err_cause_q, err_cause_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;

  logic [AW-1:0] widx;
  logic          in_range, misaligned, illegal, ld_ok, st_ok;
  logic [1:0]    cause;
  logic [31:0]   word, ext_data, merged;

  assign widx     = MEM_addr[AW+1:2];
  assign in_range = MEM_addr < BYTE_LIMIT;
  // guard the array read so a non-power-of-two depth never indexes past the end
  assign word     = in_range ? mem_q[widx] : '0;

  always_comb begin
    case (MEM_type)
      MT_B, MT_BU: misaligned = 1'b0;
      MT_H, MT_HU: misaligned = MEM_addr[0];
      MT_W:        misaligned = |MEM_addr[1:0];
      default:     misaligned = 1'b1;  // undefined codes report as misaligned
    endcase
  end

  always_comb begin
    if (MEM_rd_en && MEM_wr_en) cause = CAUSE_BOTH_EN;
    else if (!in_range)         cause = CAUSE_RANGE;
    else if (misaligned)        cause = CAUSE_MISALIGN;
    else                        cause = CAUSE_NONE;
  end

  assign illegal = (MEM_rd_en || MEM_wr_en) && (cause != CAUSE_NONE);
  assign ld_ok   = MEM_rd_en && !illegal;
  assign st_ok   = MEM_wr_en && !illegal;

  mem_lane_align u_align (
    .word_i    (word),
    .off_i     (MEM_addr[1:0]),
    .type_i    (MEM_type),
    .wr_data_i (MEM_WR_out),
    .rd_data_o (ext_data),
    .wr_word_o (merged)
  );

  assign MEM_data = ld_ok ? ext_data : '0;

  // RAM is never cleared; reset only suppresses the store in that cycle
  always_ff @(posedge CLK) begin
    if (rst && st_ok) mem_q[widx] <= merged;
  end

  always_comb begin
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    if (illegal && !err_q) begin
      err_d       = 1'b1;
      err_addr_d  = MEM_addr;
      err_cause_d = cause;
    end
    ld_cnt_d = (ld_ok && !(&ld_cnt_q)) ? ld_cnt_q + 1'b1 : ld_cnt_q;
    st_cnt_d = (st_ok && !(&st_cnt_q)) ? st_cnt_q + 1'b1 : st_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
      ld_cnt_q    <= '0;
      st_cnt_q    <= '0;
    end else begin
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
      ld_cnt_q    <= ld_cnt_d;
      st_cnt_q    <= st_cnt_d;
    end
  end

  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;
  assign ld_count  = ld_cnt_q;
  assign st_count  = st_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  logic        CLK = 1'b0;
  logic        rst;
  logic [31:0] MEM_addr, MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en, MEM_wr_en;
  logic [31:0] MEM_data;
  logic        err;
  logic [31:0] err_addr;
  logic [1:0]  err_cause;
  logic [15:0] ld_count, st_count;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
    .CLK(CLK), .rst(rst), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
    .MEM_data(MEM_data), .err(err), .err_addr(err_addr), .err_cause(err_cause),
    .ld_count(ld_count), .st_count(st_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    bit          data_dc;
    logic        err;
    logic [31:0] eaddr;
    logic [1:0]  cause;
    logic [15:0] ld;
    logic [15:0] st;
    string       tag;
  } exp_t;

  exp_t q[$];

  // reference model: byte-addressed memory plus debug state
  byte unsigned mb [NBYTES];
  bit           mk [NBYTES];
  bit           m_err;
  logic [31:0]  m_eaddr;
  logic [1:0]   m_cause;
  int           m_ld, m_st;

  int checks = 0;
  int failures = 0;
  bit drv_done = 0;

  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic op(input bit r, input bit w, input logic [2:0] t,
                    input logic [31:0] a, input logic [31:0] d,
                    input bit rs, input string tag);
    exp_t e;
    int sz;
    bit rng_bad, mis, legal;
    logic [1:0] c;
    @(posedge CLK); #1;
    rst = rs; MEM_rd_en = r; MEM_wr_en = w; MEM_type = t; MEM_addr = a; MEM_WR_out = d;
    sz      = size_of(t);
    rng_bad = (a >= NBYTES);
    mis     = (sz == 0) || ((a % sz) != 0);
    c       = (r && w) ? 2'b11 : rng_bad ? 2'b10 : mis ? 2'b01 : 2'b00;
    legal   = (r || w) && (c == 2'b00);
    e.data = 0; e.data_dc = 0; e.tag = tag;
    if (r && legal)
      for (int i = 0; i < sz; i++) begin
        if (!mk[a + i]) e.data_dc = 1;
        e.data = e.data | (32'(mb[a + i]) << (8 * i));
      end
    e.err = m_err; e.eaddr = m_eaddr; e.cause = m_cause;
    e.ld = 16'(m_ld); e.st = 16'(m_st);
    q.push_back(e);
    // state change the coming edge will make
    if (!rs) begin
      m_err = 0; m_eaddr = 0; m_cause = 0; m_ld = 0; m_st = 0;
    end else begin
      if (legal && w)
        for (int i = 0; i < sz; i++) begin
          mb[a + i] = byte'(d >> (8 * i));
          mk[a + i] = 1;
        end
      if (legal && r && m_ld < 65535) m_ld++;
      if (legal && w && m_st < 65535) m_st++;
      if ((r || w) && !legal && !m_err) begin
        m_err = 1; m_eaddr = a; m_cause = c;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // monitor: every driven cycle presents one observation, sampled at negedge
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.data_dc) chk({e.tag, " MEM_data"}, MEM_data, e.data);
      chk({e.tag, " err"},       32'(err),       32'(e.err));
      chk({e.tag, " err_addr"},  err_addr,       e.eaddr);
      chk({e.tag, " err_cause"}, 32'(err_cause), 32'(e.cause));
      chk({e.tag, " ld_count"},  32'(ld_count),  32'(e.ld));
      chk({e.tag, " st_count"},  32'(st_count),  32'(e.st));
    end
  end

  initial begin
    rst = 0; MEM_rd_en = 0; MEM_wr_en = 0; MEM_type = 0; MEM_addr = 0; MEM_WR_out = 0;
    repeat (2) @(posedge CLK);
    m_err = 0; m_eaddr = 0; m_cause = 0; m_ld = 0; m_st = 0;

    op(0, 0, 3'd2, 32'h0,    32'h0,        1, "reset_state");
    // directed cases
    op(0, 1, 3'd2, 32'h10,   32'hDEADBEEF, 1, "sw10");
    op(1, 0, 3'd2, 32'h10,   32'h0,        1, "lw10");
    op(0, 1, 3'd0, 32'h11,   32'h123456AA, 1, "sb11");
    op(1, 0, 3'd2, 32'h10,   32'h0,        1, "lw10_b");
    op(1, 0, 3'd0, 32'h11,   32'h0,        1, "lb11");
    op(0, 1, 3'd1, 32'h12,   32'h0000CAFE, 1, "sh12");
    op(1, 0, 3'd5, 32'h12,   32'h0,        1, "lhu12");
    op(1, 0, 3'd2, 32'h10,   32'h0,        1, "lw10_c");
    op(1, 0, 3'd2, 32'h13,   32'h0,        1, "lw13_mis");
    op(1, 0, 3'd2, 32'h1000, 32'h0,        1, "lw_oor");
    op(1, 0, 3'd0, 32'hFFF,  32'h0,        1, "lb_top");
    op(0, 0, 3'd2, 32'h0,    32'h0,        0, "rst1");
    op(1, 1, 3'd2, 32'h20,   32'h55,       1, "both_en");
    op(1, 0, 3'd2, 32'h20,   32'h0,        1, "lw20");
    op(1, 0, 3'd3, 32'h10,   32'h0,        1, "undef_t");
    op(0, 1, 3'd2, 32'h30,   32'h77,       0, "rst_sw30");
    op(1, 0, 3'd2, 32'h10,   32'h0,        1, "lw10_post");
    op(1, 0, 3'd2, 32'h30,   32'h0,        1, "lw30_post");

    // known contents for the random region
    for (int i = 0; i < 64; i++)
      op(0, 1, 3'd2, 32'(4 * i), $urandom, 1, "fill");

    for (int n = 0; n < 400; n++) begin
      int k;
      logic [31:0] a;
      bit r, w;
      k = int'($urandom_range(0, 19));
      a = (k == 0) ? 32'($urandom_range(NBYTES, 2 * NBYTES)) : 32'($urandom_range(0, 255));
      k = int'($urandom_range(0, 19));
      r = (k < 9) || (k == 19);
      w = (k >= 9 && k < 17) || (k == 19);
      op(r, w, 3'($urandom_range(0, 7)), a, $urandom, (n % 60) != 59, "rand");
    end

    op(0, 0, 3'd0, 32'h0, 32'h0, 1, "tail");
    drv_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (drv_done);
    while (q.size() > 0 && budget < 100) begin
      @(posedge CLK);
      budget++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d observations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
